// File: rtl/etype_cfg_pkg.sv
// Ethertype parser config controller: shared types.
// Register map, flag layout and commit FSM states.
package etype_cfg_pkg;

  localparam logic [3:0] ADDR_FLAGS   = 4'h0;
  localparam logic [3:0] ADDR_CAM     = 4'h1;
  localparam logic [3:0] ADDR_ETYPE0  = 4'h2;
  localparam logic [3:0] ADDR_CLR_ERR = 4'hF;

  localparam int FL_ALL         = 0;
  localparam int FL_IP4         = 1;
  localparam int FL_IP6         = 2;
  localparam int FL_ARP         = 3;
  localparam int FL_RAW         = 4;
  localparam int FL_BC          = 5;
  localparam int FL_MC          = 6;
  localparam int FL_BC_ARP_ONLY = 7;
  localparam int FL_MC_IP_ONLY  = 8;

  localparam int CAM_ALL = 0;
  localparam int CAM_IP4 = 1;
  localparam int CAM_IP6 = 2;
  localparam int CAM_ARP = 3;
  localparam int CAM_RAW = 4;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } commit_state_t;

  typedef struct packed {
    logic mc_ip_only;
    logic bc_arp_only;
    logic mc;
    logic bc;
    logic raw;
    logic arp;
    logic ip6;
    logic ip4;
    logic all;
  } etype_flags_t;

  typedef struct packed {
    logic raw;
    logic arp;
    logic ip6;
    logic ip4;
    logic all;
  } etype_cam_t;

  localparam etype_flags_t FLAGS_RST = '0;
  localparam etype_cam_t   CAM_RST   = 5'b00001;

  function automatic logic [15:0] flags_word(
    etype_flags_t f
  );
    return {7'd0, f};
  endfunction

  function automatic logic [15:0] cam_word(
    etype_cam_t c
  );
    return {11'd0, c};
  endfunction

endpackage

// File: rtl/etype_cfg_ctrl_if.sv
// Register port of the ethertype config controller.
// Master is the CPU side, slave is the controller.
interface etype_cfg_ctrl_if #(
  parameter int AXIS_ID_WIDTH = 4
);

  logic                     cfg_wr_en;
  logic [AXIS_ID_WIDTH-1:0] cfg_id;
  logic [3:0]               cfg_addr;
  logic [15:0]              cfg_wr_data;
  logic                     cfg_rd_en;
  logic                     cfg_rd_active;
  logic [15:0]              cfg_rd_data;
  logic                     cfg_rd_valid;
  logic                     cfg_commit;
  logic                     cfg_busy;
  logic                     cfg_commit_done;
  logic                     cfg_timeout_err;

  modport master (
    output cfg_wr_en,
    output cfg_id,
    output cfg_addr,
    output cfg_wr_data,
    output cfg_rd_en,
    output cfg_rd_active,
    output cfg_commit,
    input  cfg_rd_data,
    input  cfg_rd_valid,
    input  cfg_busy,
    input  cfg_commit_done,
    input  cfg_timeout_err
  );

  modport slave (
    input  cfg_wr_en,
    input  cfg_id,
    input  cfg_addr,
    input  cfg_wr_data,
    input  cfg_rd_en,
    input  cfg_rd_active,
    input  cfg_commit,
    output cfg_rd_data,
    output cfg_rd_valid,
    output cfg_busy,
    output cfg_commit_done,
    output cfg_timeout_err
  );

endinterface

// File: rtl/etype_cfg_pkt_tracker.sv
// Tracks whether the parser input stream is mid-packet.
// safe marks a cycle where config may change.
module etype_cfg_pkt_tracker (
  input  logic aclk,
  input  logic areset,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  output logic safe
);

  logic in_pkt;

  // open on a non-last beat, close on the last beat
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_pkt <= 1'b0;
    end else if (tvalid && tready) begin
      in_pkt <= !tlast;
    end
  end

  assign safe = !in_pkt && !tvalid;

endmodule

// File: rtl/etype_cfg_ctrl.sv
// Ethertype parser ACL/CAM config: shadow/active copies
// with commit deferred to a packet boundary.
module etype_cfg_ctrl
  import etype_cfg_pkg::*;
#(
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int NUM_CONFIG_ETYPES = 2,
  parameter int COMMIT_TIMEOUT    = 4096
) (
  input  logic aclk,
  input  logic areset,

  input  logic axis_in_tvalid,
  input  logic axis_in_tready,
  input  logic axis_in_tlast,

  etype_cfg_ctrl_if.slave cfg,

  input  logic [AXIS_ID_WIDTH-1:0] etype_sel_id,

  output logic etype_allow_all,
  output logic etype_allow_next_ip4,
  output logic etype_allow_next_ip6,
  output logic etype_allow_next_arp,
  output logic etype_allow_next_raw,
  output logic etype_allow_bc,
  output logic etype_allow_mc,
  output logic etype_allow_bc_arp_only,
  output logic etype_allow_mc_ip_only,

  output logic [16*NUM_CONFIG_ETYPES-1:0] etype_config,

  output logic [2**AXIS_ID_WIDTH-1:0] etype_allow_all_cam,
  output logic [2**AXIS_ID_WIDTH-1:0] etype_allow_next_ip4_cam,
  output logic [2**AXIS_ID_WIDTH-1:0] etype_allow_next_ip6_cam,
  output logic [2**AXIS_ID_WIDTH-1:0] etype_allow_next_arp_cam,
  output logic [2**AXIS_ID_WIDTH-1:0] etype_allow_next_raw_cam
);

  localparam int NID = 2**AXIS_ID_WIDTH;
  localparam int NE  = NUM_CONFIG_ETYPES;
  localparam int CW  = (COMMIT_TIMEOUT > 0)
                     ? $clog2(COMMIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    (COMMIT_TIMEOUT > 0) ? CW'(COMMIT_TIMEOUT - 1) : '0;

  etype_flags_t sh_fl  [NID];
  etype_flags_t ac_fl  [NID];
  etype_cam_t   sh_cam [NID];
  etype_cam_t   ac_cam [NID];
  logic [15:0]  sh_et  [NE];
  logic [15:0]  ac_et  [NE];

  commit_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          copy;
  logic          tmo;
  logic          safe;

  logic          wr_fl;
  logic          wr_cam;
  logic          wr_clr;
  logic [NE-1:0] wr_et;

  logic          done_q;
  logic          err_q;
  logic [15:0]   rd_mux;
  logic [15:0]   rd_q;
  logic          rd_vld_q;

  etype_flags_t  sel_fl;

  etype_cfg_pkt_tracker u_trk (
    .aclk   (aclk),
    .areset (areset),
    .tvalid (axis_in_tvalid),
    .tready (axis_in_tready),
    .tlast  (axis_in_tlast),
    .safe   (safe)
  );

  // register write decode
  always_comb begin
    wr_fl  = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_FLAGS);
    wr_cam = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_CAM);
    wr_clr = cfg.cfg_wr_en && (cfg.cfg_addr == ADDR_CLR_ERR);
    wr_et  = '0;
    for (int k = 0; k < NE; k++) begin
      wr_et[k] = cfg.cfg_wr_en &&
        (cfg.cfg_addr == 4'(ADDR_ETYPE0 + k));
    end
  end

  // shadow copies take every write immediately
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NID; i++) begin
        sh_fl[i]  <= FLAGS_RST;
        sh_cam[i] <= CAM_RST;
      end
      for (int k = 0; k < NE; k++) begin
        sh_et[k] <= '0;
      end
    end else begin
      if (wr_fl) begin
        sh_fl[cfg.cfg_id] <= cfg.cfg_wr_data[8:0];
      end
      if (wr_cam) begin
        sh_cam[cfg.cfg_id] <= cfg.cfg_wr_data[4:0];
      end
      for (int k = 0; k < NE; k++) begin
        if (wr_et[k]) begin
          sh_et[k] <= cfg.cfg_wr_data;
        end
      end
    end
  end

  // active copies load pre-write shadow on commit
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NID; i++) begin
        ac_fl[i]  <= FLAGS_RST;
        ac_cam[i] <= CAM_RST;
      end
      for (int k = 0; k < NE; k++) begin
        ac_et[k] <= '0;
      end
    end else if (copy) begin
      for (int i = 0; i < NID; i++) begin
        ac_fl[i]  <= sh_fl[i];
        ac_cam[i] <= sh_cam[i];
      end
      for (int k = 0; k < NE; k++) begin
        ac_et[k] <= sh_et[k];
      end
    end
  end

  // commit FSM state and wait counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // commit FSM: copy at a boundary or on timeout
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    copy      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg.cfg_commit) begin
          if (safe) begin
            copy      = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = PEND;
            cnt_nxt   = '0;
          end
        end
      end
      PEND: begin
        cnt_nxt = cnt + 1'b1;
        if (safe) begin
          copy      = 1'b1;
          state_nxt = DONE;
        end else if (COMMIT_TIMEOUT != 0 &&
                     cnt == CNT_LAST) begin
          copy      = 1'b1;
          tmo       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // done pulse and sticky timeout flag
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (tmo) begin
        err_q <= 1'b1;
      end else if (wr_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // read mux over shadow or active copy
  always_comb begin
    rd_mux = '0;
    if (cfg.cfg_addr == ADDR_FLAGS) begin
      rd_mux = cfg.cfg_rd_active
             ? flags_word(ac_fl[cfg.cfg_id])
             : flags_word(sh_fl[cfg.cfg_id]);
    end else if (cfg.cfg_addr == ADDR_CAM) begin
      rd_mux = cfg.cfg_rd_active
             ? cam_word(ac_cam[cfg.cfg_id])
             : cam_word(sh_cam[cfg.cfg_id]);
    end else begin
      for (int k = 0; k < NE; k++) begin
        if (cfg.cfg_addr == 4'(ADDR_ETYPE0 + k)) begin
          rd_mux = cfg.cfg_rd_active
                 ? ac_et[k] : sh_et[k];
        end
      end
    end
  end

  // registered read response
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= cfg.cfg_rd_en;
      if (cfg.cfg_rd_en) begin
        rd_q <= rd_mux;
      end
    end
  end

  assign cfg.cfg_rd_data     = rd_q;
  assign cfg.cfg_rd_valid    = rd_vld_q;
  assign cfg.cfg_busy        = (state != IDLE);
  assign cfg.cfg_commit_done = done_q;
  assign cfg.cfg_timeout_err = err_q;

  assign sel_fl = ac_fl[etype_sel_id];

  assign etype_allow_all         = sel_fl.all;
  assign etype_allow_next_ip4    = sel_fl.ip4;
  assign etype_allow_next_ip6    = sel_fl.ip6;
  assign etype_allow_next_arp    = sel_fl.arp;
  assign etype_allow_next_raw    = sel_fl.raw;
  assign etype_allow_bc          = sel_fl.bc;
  assign etype_allow_mc          = sel_fl.mc;
  assign etype_allow_bc_arp_only = sel_fl.bc_arp_only;
  assign etype_allow_mc_ip_only  = sel_fl.mc_ip_only;

  for (genvar k = 0; k < NE; k++) begin : g_et
    assign etype_config[16*k +: 16] = ac_et[k];
  end

  for (genvar i = 0; i < NID; i++) begin : g_cam
    assign etype_allow_all_cam[i]      = ac_cam[i].all;
    assign etype_allow_next_ip4_cam[i] = ac_cam[i].ip4;
    assign etype_allow_next_ip6_cam[i] = ac_cam[i].ip6;
    assign etype_allow_next_arp_cam[i] = ac_cam[i].arp;
    assign etype_allow_next_raw_cam[i] = ac_cam[i].raw;
  end

endmodule

// File: tb/tb_etype_cfg_ctrl.sv
// Scoreboard bench for etype_cfg_ctrl with a
// behavioural shadow/active config model.
module tb_etype_cfg_ctrl;
  import etype_cfg_pkg::*;

  localparam int IW  = 4;
  localparam int NID = 16;
  localparam int NE  = 2;
  localparam int TO  = 16;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  always #5 aclk = ~aclk;

  logic tvalid = 1'b0;
  logic tready = 1'b0;
  logic tlast  = 1'b0;
  logic [IW-1:0] sel = '0;

  logic al_all, al_ip4, al_ip6, al_arp, al_raw;
  logic al_bc, al_mc, al_bcarp, al_mcip;
  logic [16*NE-1:0] et_cfg;
  logic [NID-1:0] c_all, c_ip4, c_ip6, c_arp, c_raw;
  logic [8:0] dut_fl;

  etype_cfg_ctrl_if #(.AXIS_ID_WIDTH(IW)) cfg ();

  etype_cfg_ctrl #(
    .AXIS_ID_WIDTH     (IW),
    .NUM_CONFIG_ETYPES (NE),
    .COMMIT_TIMEOUT    (TO)
  ) dut (
    .aclk                     (aclk),
    .areset                   (areset),
    .axis_in_tvalid           (tvalid),
    .axis_in_tready           (tready),
    .axis_in_tlast            (tlast),
    .cfg                      (cfg),
    .etype_sel_id             (sel),
    .etype_allow_all          (al_all),
    .etype_allow_next_ip4     (al_ip4),
    .etype_allow_next_ip6     (al_ip6),
    .etype_allow_next_arp     (al_arp),
    .etype_allow_next_raw     (al_raw),
    .etype_allow_bc           (al_bc),
    .etype_allow_mc           (al_mc),
    .etype_allow_bc_arp_only  (al_bcarp),
    .etype_allow_mc_ip_only   (al_mcip),
    .etype_config             (et_cfg),
    .etype_allow_all_cam      (c_all),
    .etype_allow_next_ip4_cam (c_ip4),
    .etype_allow_next_ip6_cam (c_ip6),
    .etype_allow_next_arp_cam (c_arp),
    .etype_allow_next_raw_cam (c_raw)
  );

  assign dut_fl = {al_mcip, al_bcarp, al_mc, al_bc,
                   al_raw, al_arp, al_ip6, al_ip4, al_all};

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [15:0] rdq [$];
  int          doneq [$];

  logic [8:0]  m_sfl [NID];
  logic [8:0]  m_afl [NID];
  logic [4:0]  m_scam [NID];
  logic [4:0]  m_acam [NID];
  logic [15:0] m_set [NE];
  logic [15:0] m_aet [NE];
  bit m_err, m_req, m_post, m_inpkt;
  int m_age;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at cyc %0d",
                  nm, act, exp, cyc);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NID; i++) begin
      m_sfl[i] = '0;  m_afl[i] = '0;
      m_scam[i] = 5'd1; m_acam[i] = 5'd1;
    end
    for (int k = 0; k < NE; k++) begin
      m_set[k] = '0; m_aet[k] = '0;
    end
    m_err = 0; m_req = 0; m_post = 0;
    m_inpkt = 0; m_age = 0;
    rdq.delete();
    doneq.delete();
  endfunction

  function automatic logic [15:0] rd_model(
    logic [3:0] a, int id, bit act);
    if (a == 4'h0) return act ? 16'(m_afl[id]) : 16'(m_sfl[id]);
    if (a == 4'h1) return act ? 16'(m_acam[id]) : 16'(m_scam[id]);
    if (a >= 2 && a < 2 + NE)
      return act ? m_aet[a-2] : m_set[a-2];
    return 16'h0;
  endfunction

  // monitor: pops expectations when the DUT responds
  always @(negedge aclk) begin
    if (cfg.cfg_rd_valid) begin
      if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
      else chk("rd_data", cfg.cfg_rd_data, rdq.pop_front());
    end
    if (cfg.cfg_commit_done) begin
      done_cnt++;
      if (doneq.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_cycle", cyc, doneq.pop_front());
    end
  end

  task automatic set_idle();
    cfg.cfg_wr_en = 0; cfg.cfg_rd_en = 0;
    cfg.cfg_commit = 0; cfg.cfg_rd_active = 0;
    cfg.cfg_addr = '0; cfg.cfg_id = '0;
    cfg.cfg_wr_data = '0;
    tvalid = 0; tready = 0; tlast = 0;
  endtask

  task automatic wr(logic [3:0] a, int id, logic [15:0] d);
    cfg.cfg_wr_en = 1; cfg.cfg_addr = a;
    cfg.cfg_id = IW'(id); cfg.cfg_wr_data = d;
  endtask

  task automatic rd(logic [3:0] a, int id, bit act);
    cfg.cfg_rd_en = 1; cfg.cfg_addr = a;
    cfg.cfg_id = IW'(id); cfg.cfg_rd_active = act;
  endtask

  // one clock: check outputs, advance model, step edge
  task automatic tick();
    bit safe, copy, tmo;
    logic [3:0] a;
    int id;
    #1;
    chk("flags_sel", dut_fl, m_afl[sel]);
    for (int i = 0; i < NID; i++)
      chk("cam", {c_raw[i], c_ip4[i] & 1'b0 | c_arp[i],
                  c_ip6[i], c_ip4[i], c_all[i]},
          m_acam[i]);
    chk("etype_config", et_cfg, {m_aet[1], m_aet[0]});
    chk("busy", cfg.cfg_busy, m_req || m_post);
    chk("timeout_err", cfg.cfg_timeout_err, m_err);
    a = cfg.cfg_addr;
    id = cfg.cfg_id;
    if (cfg.cfg_rd_en)
      rdq.push_back(rd_model(a, id, cfg.cfg_rd_active));
    safe = !m_inpkt && !tvalid;
    copy = 0; tmo = 0;
    if (m_req) begin
      if (safe) copy = 1;
      else if (m_age == TO - 1) begin copy = 1; tmo = 1; end
      m_age++;
      if (copy) m_req = 0;
    end else if (!m_post && cfg.cfg_commit) begin
      if (safe) copy = 1;
      else begin m_req = 1; m_age = 0; end
    end
    m_post = copy;
    if (copy) begin
      m_afl = m_sfl; m_acam = m_scam; m_aet = m_set;
      doneq.push_back(cyc + 2);
    end
    if (cfg.cfg_wr_en) begin
      if (a == 4'h0) m_sfl[id] = cfg.cfg_wr_data[8:0];
      if (a == 4'h1) m_scam[id] = cfg.cfg_wr_data[4:0];
      if (a >= 2 && a < 2 + NE) m_set[a-2] = cfg.cfg_wr_data;
      if (a == 4'hF) m_err = 0;
    end
    if (tmo) m_err = 1;
    if (tvalid && tready) m_inpkt = !tlast;
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    set_idle();
    areset = 1;
    model_reset();
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", cfg.cfg_busy, 0);
    chk("rst_done", cfg.cfg_commit_done, 0);
    chk("rst_rd_valid", cfg.cfg_rd_valid, 0);
    chk("rst_rd_data", cfg.cfg_rd_data, 0);
    areset = 0;
  endtask

  initial begin
    int d0;
    set_idle();
    #2;
    @(negedge aclk);
    do_reset();
    set_idle(); rd(ADDR_CAM, 0, 0); tick();
    set_idle(); rd(ADDR_FLAGS, 9, 1); tick();

    // idle commit of id3 flags
    set_idle(); wr(ADDR_FLAGS, 3, 16'h0003); tick();
    set_idle(); cfg.cfg_commit = 1; tick();
    set_idle(); repeat (3) tick();
    sel = 3; #1 chk("t1_sel3", dut_fl, 9'h003);
    sel = 2; #1 chk("t1_sel2", dut_fl, 9'h000);

    // commit mid-packet waits for the boundary
    sel = 5;
    set_idle(); wr(ADDR_FLAGS, 5, 16'h01F0); tick();
    for (int b = 0; b < 5; b++) begin
      set_idle();
      tvalid = 1; tready = (b != 2); tlast = (b == 4);
      cfg.cfg_commit = (b == 1);
      tick();
    end
    set_idle(); repeat (4) tick();
    chk("t2_sel5", dut_fl, 9'h1F0);

    // back-to-back packets force a timeout commit
    set_idle(); wr(ADDR_CAM, 7, 16'h001E); tick();
    for (int k = 0; k < 32; k++) begin
      set_idle();
      tvalid = 1; tready = 1; tlast = (k % 4 == 3);
      cfg.cfg_commit = (k == 0);
      tick();
    end
    set_idle(); tick();
    chk("t3_err_set", cfg.cfg_timeout_err, 1);
    chk("t3_cam7", c_arp[7], 1);
    set_idle(); wr(ADDR_CLR_ERR, 0, 16'h0); tick();
    chk("t3_err_clr", cfg.cfg_timeout_err, 0);

    // write lands in shadow only when it meets the copy
    set_idle(); wr(4'h2, 0, 16'h88B5);
    cfg.cfg_commit = 1; tick();
    set_idle(); rd(4'h2, 0, 0); tick();
    set_idle(); rd(4'h2, 0, 1); tick();
    set_idle(); repeat (2) tick();
    chk("t4_old", et_cfg[15:0], 16'h0000);
    set_idle(); cfg.cfg_commit = 1; tick();
    set_idle(); repeat (3) tick();
    chk("t4_new", et_cfg[15:0], 16'h88B5);

    // reset while a commit is pending
    set_idle(); wr(ADDR_FLAGS, 1, 16'h1FF); tick();
    for (int k = 0; k < 4; k++) begin
      set_idle(); tvalid = 1;
      cfg.cfg_commit = (k == 0);
      tick();
    end
    do_reset();
    set_idle(); repeat (3) tick();
    chk("t5_cam_all", c_all, 16'hFFFF);
    sel = 1; #1 chk("t5_flags", dut_fl, 9'h000);

    // extra commits while busy are dropped
    d0 = done_cnt;
    set_idle(); wr(ADDR_FLAGS, 2, 16'h0041); tick();
    set_idle(); cfg.cfg_commit = 1; tick();
    set_idle(); cfg.cfg_commit = 1; tick();
    set_idle(); repeat (3) tick();
    chk("t6_one_done_a", done_cnt - d0, 1);
    d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      set_idle(); tvalid = 1;
      cfg.cfg_commit = (k == 0 || k == 3);
      tick();
    end
    set_idle(); repeat (4) tick();
    chk("t6_one_done_b", done_cnt - d0, 1);

    // randomized traffic, register access and commits
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      if ($urandom_range(0, 3) == 0)
        wr(4'($urandom_range(0, 15)),
           int'($urandom_range(0, NID - 1)),
           16'($urandom));
      if ($urandom_range(0, 3) == 0)
        rd(4'($urandom_range(0, 15)),
           int'($urandom_range(0, NID - 1)),
           1'($urandom_range(0, 1)));
      cfg.cfg_commit = ($urandom_range(0, 15) == 0);
      tvalid = ($urandom_range(0, 2) != 0);
      tready = ($urandom_range(0, 3) != 0);
      tlast  = ($urandom_range(0, 3) == 0);
      sel = IW'($urandom_range(0, NID - 1));
      tick();
    end

    set_idle(); tlast = 1; tvalid = 1; tready = 1; tick();
    set_idle(); repeat (24) tick();
    chk("rdq_drained", rdq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
